cart_rom_fetch: RTL

- Memory-side responder for cartridge mappers: takes the translated physical address produced by a mapper (e.g. cart_konami mem_addr) and serves CPU read cycles from the shared SDRAM/DDR port.
- Provides CPU wait-state generation, a one-entry last-byte buffer, out-of-image 0xFF return, and an ack timeout.
- Sits between the slot/mapper logic and the memory arbiter.

---
 rtl/cart_rom_fetch_pkg.sv | 13 +
 rtl/cart_rom_fetch.sv | 118 +++++++++++
 2 files changed

// File: rtl/cart_rom_fetch_pkg.sv
// rtl/cart_rom_fetch_pkg.sv - shared cartridge ROM fetch types and constants
package cart_rom_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam logic [7:0] ROM_OPEN_BUS = 8'hFF;
  localparam int         CART_ADDR_W  = 25;

endpackage

// File: rtl/cart_rom_fetch.sv
// rtl/cart_rom_fetch.sv - serves CPU ROM reads from the shared memory port
// with wait-states, a one-byte buffer, open-bus return and an ack timeout.
module cart_rom_fetch
  import cart_rom_fetch_pkg::*;
#(
  parameter int ADDR_W  = CART_ADDR_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rom_size,
  input  logic              flush,
  input  logic              cs,
  input  logic              rd,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        d_to_cpu,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_req,
  input  logic              ram_ack,
  input  logic [7:0]        ram_dout,
  output logic              timeout_err
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  fetch_state_t      state, state_next;
  logic              cs_q, rd_q;
  logic              ready;
  logic              valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic [15:0]       timer;

  logic access, rd_rise, out_of_range, hit, timer_done;

  assign access       = cs & rd;
  assign rd_rise      = access & ~(cs_q & rd_q);
  assign out_of_range = (mem_addr >= rom_size);
  assign hit          = valid && (buf_addr == mem_addr);
  assign timer_done   = (timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rd_rise && !out_of_range && !hit) state_next = REQ;
      REQ:     if (ram_ack || timer_done)            state_next = DONE;
      DONE:    if (!access)                          state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_req  = (state == REQ);
    cpu_wait = access & ~ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q        <= 1'b0;
      rd_q        <= 1'b0;
      ready       <= 1'b0;
      valid       <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= ROM_OPEN_BUS;
      timer       <= '0;
      ram_addr    <= '0;
      d_to_cpu    <= ROM_OPEN_BUS;
      timeout_err <= 1'b0;
    end else begin
      cs_q <= cs;
      rd_q <= rd;
      case (state)
        IDLE: begin
          if (rd_rise) begin
            if (out_of_range) begin
              d_to_cpu <= ROM_OPEN_BUS;
              ready    <= 1'b1;
            end else if (hit) begin
              d_to_cpu <= buf_data;
              ready    <= 1'b1;
            end else begin
              ram_addr <= mem_addr;
              timer    <= '0;
              ready    <= 1'b0;
            end
          end
        end
        REQ: begin
          if (ram_ack) begin
            d_to_cpu <= ram_dout;
            buf_data <= ram_dout;
            buf_addr <= ram_addr;
            valid    <= 1'b1;
            ready    <= 1'b1;
          end else if (timer_done) begin
            d_to_cpu    <= ROM_OPEN_BUS;
            timeout_err <= 1'b1;
            ready       <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: ;
      endcase
      // ready only matters while a read is held; clearing it between reads
      // makes the rd_rise cycle always stall.
      if (!access) ready <= 1'b0;
      if (flush)   valid <= 1'b0;
    end
  end

endmodule
